// File: rtl/octree_pkg.sv
// octree_pkg: shared op codes, response codes, FSM states and SRAM geometry
package octree_pkg;
   localparam int SRAM_AW = 10;
   localparam int SRAM_DW = 64;
   typedef enum logic [1:0] {OP_IDLE = 2'd0, OP_SEARCH = 2'd1, OP_ADD = 2'd2, OP_DEL = 2'd3} op_e;
   typedef enum logic [1:0] {RSP_OK = 2'd0, RSP_TIMEOUT = 2'd1, RSP_BAD_DONE = 2'd2, RSP_NOP = 2'd3} rsp_e;
   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DRAIN, S_RESP} state_e;
endpackage

// File: rtl/octree_rd_skid.sv
// octree_rd_skid: 2-entry FIFO catching in/out SRAM read data while the result stream stalls
//   push_i/wdata_i  read data returning one cycle after the read request
//   pop_i           result-stream handshake (asserted only while valid_o)
//   valid_o/data_o  head entry
//   count_o         occupancy, used by the read-issue throttle
module octree_rd_skid
   import octree_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               push_i,
   input  logic [SRAM_DW-1:0] wdata_i,
   input  logic               pop_i,
   output logic               valid_o,
   output logic [SRAM_DW-1:0] data_o,
   output logic [1:0]         count_o
);
   logic [SRAM_DW-1:0] mem_q [2];
   logic               wr_q, rd_q;
   logic [1:0]         cnt_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         wr_q  <= wr_q ^ push_i;
         rd_q  <= rd_q ^ pop_i;
         cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
      end
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q] <= wdata_i;
   assign valid_o = cnt_q != 2'd0;
   assign data_o  = mem_q[rd_q];
   assign count_o = cnt_q;
endmodule

// File: rtl/octree_host_sequencer.sv
// octree_host_sequencer: host-side command sequencer for the Octree accelerator
//   cmd_*     command port (valid/ready), fields latched on handshake
//   in_*      ADD feature-word stream written into the in/out SRAM
//   out_*     SEARCH result stream read back from the in/out SRAM (backpressured)
//   rsp_*     one-cycle completion pulse with status
//   csr_*     Octree control/status pins
//   sram_*    in/out SRAM host port (read data one cycle after a read request)
module octree_host_sequencer
   import octree_pkg::*;
#(
   parameter int TREE_LEVEL                = 4,
   parameter int ENCODE_ADDR_WIDTH         = 3 * TREE_LEVEL + $clog2(TREE_LEVEL),
   parameter int INPUT_FEATURE_START_ADDR  = 0,
   parameter int OUTPUT_FEATURE_START_ADDR = 10,
   parameter int TIMEOUT_CYCLES            = 65535
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cmd_valid_i,
   output logic                         cmd_ready_o,
   input  logic [1:0]                   cmd_op_i,
   input  logic [SRAM_AW-1:0]           cmd_len_i,
   input  logic [ENCODE_ADDR_WIDTH-1:0] cmd_pos_encode_i,
   input  logic [3:0]                   cmd_tree_num_i,
   input  logic [4:0][15:0]             cmd_lod_param_i,
   input  logic                         in_valid_i,
   output logic                         in_ready_o,
   input  logic [SRAM_DW-1:0]           in_data_i,
   output logic                         out_valid_o,
   input  logic                         out_ready_i,
   output logic [SRAM_DW-1:0]           out_data_o,
   output logic                         out_last_o,
   output logic                         rsp_valid_o,
   output logic [1:0]                   rsp_status_o,
   output logic [ENCODE_ADDR_WIDTH-1:0] csr_pos_encode_o,
   output logic [3:0]                   csr_tree_num_o,
   output logic [4:0][15:0]             csr_lod_param_o,
   output logic [1:0]                   csr_ctrl_o,
   input  logic [1:0]                   csr_op_done_i,
   output logic                         csr_local_sram_en_o,
   output logic                         csr_in_out_sram_en_o,
   output logic                         sram_req_o,
   output logic                         sram_we_o,
   output logic [SRAM_AW-1:0]           sram_addr_o,
   output logic [SRAM_DW-1:0]           sram_wdata_o,
   input  logic [SRAM_DW-1:0]           sram_rdata_i
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [SRAM_AW-1:0] IN_BASE  = SRAM_AW'(INPUT_FEATURE_START_ADDR % (1 << SRAM_AW));
   localparam logic [SRAM_AW-1:0] OUT_BASE = SRAM_AW'(OUTPUT_FEATURE_START_ADDR % (1 << SRAM_AW));
   state_e                       state_q, state_d;
   rsp_e                         st_q, st_d;
   logic [1:0]                   op_q;
   logic [SRAM_AW-1:0]           len_q, idx_q, idx_d, beat_q, beat_d;
   logic [TW-1:0]                tmo_q, tmo_d;
   logic [ENCODE_ADDR_WIDTH-1:0] pos_q;
   logic [3:0]                   tree_q;
   logic [4:0][15:0]             lod_q;
   logic                         rdy_q, pend_q, cmd_fire, ld_we, pop, issue, last_in, last_out, sk_valid;
   logic [SRAM_DW-1:0]           sk_data;
   logic [1:0]                   sk_cnt, occ;
   assign cmd_fire = cmd_valid_i & rdy_q;
   assign ld_we    = (state_q == S_LOAD) & in_valid_i;
   assign pop      = sk_valid & out_ready_i;
   // reads in flight plus skid words left after this cycle's pop must stay below 2
   assign occ      = {1'b0, pend_q} + sk_cnt - {1'b0, pop};
   assign issue    = (state_q == S_DRAIN) & (idx_q != len_q) & (occ < 2'd2);
   assign last_in  = idx_q == len_q - 1'b1;
   assign last_out = beat_q == len_q - 1'b1;
   always_comb begin
      state_d    = state_q;
      st_d       = st_q;
      idx_d      = idx_q;
      beat_d     = beat_q;
      tmo_d      = '0;
      csr_ctrl_o = OP_IDLE;
      case (state_q)
         S_IDLE: if (cmd_fire) begin
            state_d = cmd_op_i == OP_IDLE ? S_RESP : (cmd_op_i == OP_ADD && cmd_len_i != '0) ? S_LOAD : S_KICK;
            st_d    = cmd_op_i == OP_IDLE ? RSP_NOP : RSP_OK;
            idx_d   = '0;
            beat_d  = '0;
         end
         S_LOAD: if (ld_we) begin
            idx_d   = last_in ? '0 : idx_q + 1'b1;
            state_d = last_in ? S_KICK : S_LOAD;
         end
         S_KICK: begin
            csr_ctrl_o = op_q;
            state_d    = S_WAIT;
         end
         S_WAIT: if (csr_op_done_i != 2'd0) begin
            st_d    = csr_op_done_i == op_q ? RSP_OK : RSP_BAD_DONE;
            state_d = (csr_op_done_i == op_q && op_q == OP_SEARCH && len_q != '0) ? S_DRAIN : S_RESP;
         end else if (tmo_q == TW'(TIMEOUT_CYCLES)) begin
            st_d    = RSP_TIMEOUT;
            state_d = S_RESP;
         end else begin
            csr_ctrl_o = op_q;
            tmo_d      = tmo_q + 1'b1;
         end
         S_DRAIN: begin
            idx_d   = idx_q + {{(SRAM_AW-1){1'b0}}, issue};
            beat_d  = beat_q + {{(SRAM_AW-1){1'b0}}, pop};
            state_d = (pop && last_out) ? S_RESP : S_DRAIN;
         end
         S_RESP: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= S_IDLE;
         st_q    <= RSP_OK;
         op_q    <= 2'd0;
         len_q   <= '0;
         idx_q   <= '0;
         beat_q  <= '0;
         tmo_q   <= '0;
         pos_q   <= '0;
         tree_q  <= '0;
         lod_q   <= '0;
         rdy_q   <= 1'b0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         st_q    <= st_d;
         idx_q   <= idx_d;
         beat_q  <= beat_d;
         tmo_q   <= tmo_d;
         rdy_q   <= state_d == S_IDLE;
         pend_q  <= issue;
         if (cmd_fire) begin
            op_q   <= cmd_op_i;
            len_q  <= cmd_len_i;
            pos_q  <= cmd_pos_encode_i;
            tree_q <= cmd_tree_num_i;
            lod_q  <= cmd_lod_param_i;
         end
      end
   octree_rd_skid u_skid (
      .clk     (clk),
      .rst     (rst),
      .push_i  (pend_q),
      .wdata_i (sram_rdata_i),
      .pop_i   (pop),
      .valid_o (sk_valid),
      .data_o  (sk_data),
      .count_o (sk_cnt)
   );
   assign cmd_ready_o          = rdy_q;
   assign in_ready_o           = state_q == S_LOAD;
   assign csr_in_out_sram_en_o = (state_q == S_LOAD) | (state_q == S_DRAIN);
   assign csr_local_sram_en_o  = 1'b0;
   assign sram_req_o           = ld_we | issue;
   assign sram_we_o            = ld_we;
   assign sram_addr_o          = ld_we ? IN_BASE + idx_q : issue ? OUT_BASE + idx_q : '0;
   assign sram_wdata_o         = ld_we ? in_data_i : '0;
   assign out_valid_o          = sk_valid;
   assign out_data_o           = sk_valid ? sk_data : '0;
   assign out_last_o           = sk_valid & last_out;
   assign rsp_valid_o          = state_q == S_RESP;
   assign rsp_status_o         = st_q;
   assign csr_pos_encode_o     = pos_q;
   assign csr_tree_num_o       = tree_q;
   assign csr_lod_param_o      = lod_q;
endmodule
